// File: rtl/wb_stage_if.sv
// Bundle between the memory stage, the writeback stage and the register file / forwarding network.
// The stage itself uses the slave view; whoever feeds the MEM/WB bundle uses the master view.
interface wb_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic                    in_valid;
    logic                    in_ready;
    logic                    stall;
    logic                    flush;
    logic                    crt_wb_in;
    logic [SEL_W-1:0]        wb_sel_in;
    logic [REG_AW-1:0]       rd_in;
    logic [2:0]              load_fmt_in;
    logic [OFF_W-1:0]        byte_off_in;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic                    rf_we;
    logic [REG_AW-1:0]       rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    fwd_valid;
    logic [REG_AW-1:0]       fwd_rd;
    logic [XLEN-1:0]         fwd_data;
    logic                    misalign;
    logic [CNT_W-1:0]        retire_cnt;

    modport master (
        output in_valid, stall, flush, crt_wb_in, wb_sel_in, rd_in,
               load_fmt_in, byte_off_in, src_data,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd,
               fwd_data, misalign, retire_cnt
    );

    modport slave (
        input  in_valid, stall, flush, crt_wb_in, wb_sel_in, rd_in,
               load_fmt_in, byte_off_in, src_data,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd,
               fwd_data, misalign, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Registered writeback stage: selects the result, formats load data, drives the
// register-file write port and forwarding path, flags misaligned loads, counts retirements.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input logic       clk,
    input logic       rst_n,
    wb_stage_if.slave bus
);
    logic              accept;
    logic [XLEN-1:0]   src0;
    logic [31:0]       lane;
    logic [XLEN-1:0]   fmt_data;
    logic [XLEN-1:0]   sel_data;
    logic              load_mis;
    logic              mis;

    logic              v_q;
    logic              wq_q;
    logic              mis_q;
    logic [REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    assign accept      = bus.in_valid & ~bus.stall & ~bus.flush;
    assign bus.in_ready = ~bus.stall;

    // The addressed lane is shifted down to bit 0 so every format reads from the bottom.
    assign src0 = bus.src_data[XLEN-1:0];
    assign lane = 32'(src0 >> {bus.byte_off_in, 3'b000});

    always_comb begin
        fmt_data = src0;
        load_mis = 1'b0;
        case (bus.load_fmt_in)
            3'b000: fmt_data = XLEN'(signed'(lane[7:0]));
            3'b001: begin
                fmt_data = XLEN'(signed'(lane[15:0]));
                load_mis = bus.byte_off_in[0];
            end
            3'b010: begin
                fmt_data = XLEN'(signed'(lane));
                load_mis = |bus.byte_off_in[1:0];
            end
            3'b100: fmt_data = XLEN'(lane[7:0]);
            3'b101: begin
                fmt_data = XLEN'(lane[15:0]);
                load_mis = bus.byte_off_in[0];
            end
            3'b110: if (XLEN == 64) begin
                fmt_data = XLEN'(lane);
                load_mis = |bus.byte_off_in[1:0];
            end
            3'b011: if (XLEN == 64) load_mis = |bus.byte_off_in;
            default: ;
        endcase
    end

    // Out-of-range selects fall through to zero data.
    always_comb begin
        sel_data = '0;
        for (int k = 1; k < NUM_SRC; k++) begin
            if (int'(bus.wb_sel_in) == k) sel_data = bus.src_data[k*XLEN +: XLEN];
        end
        if (bus.wb_sel_in == '0) sel_data = fmt_data;
    end

    assign mis = (bus.wb_sel_in == '0) & load_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= 1'b0;
            wq_q    <= 1'b0;
            mis_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            v_q <= accept;
            if (accept) begin
                waddr_q <= bus.rd_in;
                wdata_q <= sel_data;
                wq_q    <= bus.crt_wb_in & (bus.rd_in != '0) & ~mis;
                mis_q   <= mis;
            end
            if (v_q) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.rf_we      = v_q & wq_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.fwd_valid  = v_q & wq_q;
    assign bus.fwd_rd     = waddr_q;
    assign bus.fwd_data   = wdata_q;
    assign bus.misalign   = v_q & mis_q;
    assign bus.retire_cnt = cnt_q;
endmodule
